// File: rtl/ats21_pkg.sv
// ATS21 shared constants and the alarm event record.
// Used by the ATS21 timer and by its downstream event queue.
package ats21_pkg;

  localparam int NUM_ALARMS = 24;
  localparam int ALARM_ID_W = 5;
  localparam int TS_WIDTH   = 16;

  typedef struct packed {
    logic [ALARM_ID_W-1:0] id;
    logic [TS_WIDTH-1:0]   ts;
  } alarm_evt_t;

endpackage

// File: rtl/ats21_evt_fifo.sv
// First-word-fall-through FIFO of alarm events.
// Pointers carry an extra MSB so full and empty are distinguishable.
module ats21_evt_fifo
  import ats21_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  alarm_evt_t wdata,
  input  logic       pop,
  output alarm_evt_t rdata,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  alarm_evt_t  mem_q [DEPTH];
  alarm_evt_t  mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot, so a full FIFO may push in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ats21_event_queue.sv
// Turns ATS21 alarm pulses into a timestamped event stream.
// Edge detect, per-alarm pending slot, lowest-index grant, loss counting.
module ats21_event_queue
  import ats21_pkg::*;
#(
  parameter int NUM_ALARMS = ats21_pkg::NUM_ALARMS,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = ats21_pkg::TS_WIDTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] alarm_in,
  input  logic                  pop,
  input  logic                  clear_ovf,
  output logic                  valid,
  output logic [ALARM_ID_W-1:0] evt_id,
  output logic [TS_WIDTH-1:0]   evt_ts,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int DW = $clog2(NUM_ALARMS + 1);

  logic [NUM_ALARMS-1:0] alarm_q, alarm_d;
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [TS_WIDTH-1:0]   pend_ts_q [NUM_ALARMS];
  logic [TS_WIDTH-1:0]   pend_ts_d [NUM_ALARMS];
  logic [TS_WIDTH-1:0]   ts_ctr_q, ts_ctr_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_q, drop_d;

  logic [NUM_ALARMS-1:0] rise;
  logic [NUM_ALARMS-1:0] held;
  logic [NUM_ALARMS-1:0] drops;
  logic [NUM_ALARMS-1:0] gnt_vec;
  logic [ALARM_ID_W-1:0] gnt_idx;
  logic                  gnt_vld;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DW-1:0]         ndrop;
  logic [8:0]            drop_sum;
  alarm_evt_t            push_evt;
  alarm_evt_t            head;

  assign rise    = alarm_in & ~alarm_q;
  assign alarm_d = alarm_in;
  assign gnt_vld = (|pending_q) & (~fifo_full | pop);

  always_comb begin
    gnt_idx = '0;
    gnt_vec = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        gnt_idx = ALARM_ID_W'(i);
      end
    end
    if (gnt_vld) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  assign push_evt.id = gnt_idx;
  assign push_evt.ts = pend_ts_q[gnt_idx];

  // A granted slot is free again, so a rise on it re-arms instead of dropping
  always_comb begin
    held      = pending_q & ~gnt_vec;
    drops     = rise & held;
    pending_d = held | rise;
    pend_ts_d = pend_ts_q;
    ndrop     = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rise[i] && !held[i]) begin
        pend_ts_d[i] = ts_ctr_q;
      end
      ndrop = ndrop + DW'(drops[i]);
    end
  end

  always_comb begin
    ts_ctr_d   = ts_ctr_q + TS_WIDTH'(1);
    drop_sum   = {1'b0, (clear_ovf ? 8'd0 : drop_q)} + 9'(ndrop);
    drop_d     = drop_sum[8] ? 8'd255 : drop_sum[7:0];
    overflow_d = (overflow_q & ~clear_ovf) | (|drops);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q    <= '0;
      pending_q  <= '0;
      ts_ctr_q   <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        pend_ts_q[i] <= '0;
      end
    end else begin
      alarm_q    <= alarm_d;
      pending_q  <= pending_d;
      ts_ctr_q   <= ts_ctr_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      pend_ts_q  <= pend_ts_d;
    end
  end

  ats21_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_vld),
    .wdata (push_evt),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign valid      = ~fifo_empty;
  assign evt_id     = head.id;
  assign evt_ts     = head.ts;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_ats21_event_queue.sv
// Directed bench for the ATS21 event queue.
`timescale 1ns/1ps
module tb_ats21_event_queue;

  localparam int NA  = 24;
  localparam int TSW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NA-1:0]   alarm_in;
  logic            pop;
  logic            clear_ovf;
  logic            valid;
  logic [4:0]      evt_id;
  logic [TSW-1:0]  evt_ts;
  logic [3:0]      count;
  logic            overflow;
  logic [7:0]      drop_count;

  int checks = 0;
  int errors = 0;
  logic [TSW-1:0] tb_ts;

  ats21_event_queue dut (
    .clk        (clk),
    .reset      (reset),
    .alarm_in   (alarm_in),
    .pop        (pop),
    .clear_ovf  (clear_ovf),
    .valid      (valid),
    .evt_id     (evt_id),
    .evt_ts     (evt_ts),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // reference timestamp: cycles since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 16'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_pop;
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; alarm_in = '0; pop = 1'b0; clear_ovf = 1'b0;
    tick(); tick();
    checks++;
    if ({valid, evt_id, evt_ts, count, overflow, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b id=%0d ts=%0d cnt=%0d ovf=%0b drop=%0d exp all 0",
               valid, evt_id, evt_ts, count, overflow, drop_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    while (tb_ts != 16'd10) tick();
    alarm_in[3] = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_latency valid got %0b exp 0", valid); end
    tick();
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", valid); end
    checks++;
    if (evt_id !== 5'd3) begin errors++; $display("FAIL single_id got %0d exp 3", evt_id); end
    checks++;
    if (evt_ts !== 16'd10) begin errors++; $display("FAIL single_ts got %0d exp 10", evt_ts); end
    alarm_in = '0;
    tick();
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL single_one_event count got %0d exp 1", count); end
    do_pop();
    checks++;
    if ({valid, count, evt_id} !== '0) begin
      errors++;
      $display("FAIL single_after_pop got v=%0b cnt=%0d id=%0d exp 0", valid, count, evt_id);
    end
  endtask

  task automatic test_simultaneous;
    int ids [3] = '{0, 8, 23};
    logic [TSW-1:0] t;
    t = tb_ts;
    alarm_in = 24'h800101;
    tick();
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL simul_c0 got %0d exp 0", count); end
    tick();
    alarm_in = '0;
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL simul_c1 got %0d exp 1", count); end
    tick();
    checks++;
    if (count !== 4'd2) begin errors++; $display("FAIL simul_c2 got %0d exp 2", count); end
    tick();
    checks++;
    if (count !== 4'd3) begin errors++; $display("FAIL simul_c3 got %0d exp 3", count); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (evt_id !== 5'(ids[k]) || evt_ts !== t) begin
        errors++;
        $display("FAIL simul_head%0d got id=%0d ts=%0d exp id=%0d ts=%0d", k, evt_id, evt_ts, ids[k], t);
      end
      do_pop();
    end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL simul_drained got %0d exp 0", count); end
  endtask

  task automatic test_full;
    logic [TSW-1:0] t;
    t = tb_ts;
    alarm_in = 24'h0001FF;
    tick(); tick();
    alarm_in = '0;
    repeat (7) tick();
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
    repeat (3) tick();
    checks++;
    if (count !== 4'd8 || evt_id !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_hold got cnt=%0d id=%0d ovf=%0b exp 8/0/0", count, evt_id, overflow);
    end
    do_pop();
    checks++;
    if (count !== 4'd8 || evt_id !== 5'd1) begin
      errors++;
      $display("FAIL full_refill got cnt=%0d id=%0d exp 8/1", count, evt_id);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (evt_id !== 5'(k) || evt_ts !== t) begin
        errors++;
        $display("FAIL full_head%0d got id=%0d ts=%0d exp id=%0d ts=%0d", k, evt_id, evt_ts, k, t);
      end
      do_pop();
    end
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_drained got cnt=%0d ovf=%0b exp 0/0", count, overflow);
    end
  endtask

  task automatic test_drop;
    int ids [8] = '{0, 1, 2, 3, 4, 6, 7, 8};
    logic [TSW-1:0] t;
    logic [TSW-1:0] t5;
    t = tb_ts;
    alarm_in = 24'h0001DF;
    tick(); tick();
    alarm_in = '0;
    repeat (7) tick();
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL drop_fill got %0d exp 8", count); end
    t5 = tb_ts;
    alarm_in = 24'h000020;
    tick(); tick();
    alarm_in = '0;
    tick();
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL drop_pending got ovf=%0b drop=%0d exp 0/0", overflow, drop_count);
    end
    alarm_in = 24'h000020;
    tick();
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL drop_first got ovf=%0b drop=%0d exp 1/1", overflow, drop_count);
    end
    alarm_in = '0;
    tick();
    repeat (300) begin
      alarm_in = 24'h000020; tick();
      alarm_in = '0;         tick();
    end
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd255 || count !== 4'd8) begin
      errors++;
      $display("FAIL drop_saturate got ovf=%0b drop=%0d cnt=%0d exp 1/255/8", overflow, drop_count, count);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (evt_id !== 5'(ids[k]) || evt_ts !== t) begin
        errors++;
        $display("FAIL drop_head%0d got id=%0d ts=%0d exp id=%0d ts=%0d", k, evt_id, evt_ts, ids[k], t);
      end
      do_pop();
    end
    checks++;
    if (evt_id !== 5'd5 || evt_ts !== t5 || count !== 4'd1) begin
      errors++;
      $display("FAIL drop_orig_ts got id=%0d ts=%0d cnt=%0d exp id=5 ts=%0d cnt=1", evt_id, evt_ts, count, t5);
    end
    do_pop();
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL drop_drained got %0d exp 0", count); end
  endtask

  task automatic test_clear;
    int ids [5] = '{0, 1, 2, 3, 10};
    logic [TSW-1:0] t;
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_alone got ovf=%0b drop=%0d exp 0/0", overflow, drop_count);
    end
    t = tb_ts;
    alarm_in = 24'h00040F; tick();
    alarm_in = 24'h00000F; tick();
    alarm_in = 24'h000400; tick();
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL clear_pre_drop got ovf=%0b drop=%0d exp 1/1", overflow, drop_count);
    end
    alarm_in = '0; tick();
    alarm_in = 24'h000400; clear_ovf = 1'b1; tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL clear_vs_drop got ovf=%0b drop=%0d exp 1/1", overflow, drop_count);
    end
    alarm_in = '0; tick();
    checks++;
    if (count !== 4'd5) begin errors++; $display("FAIL clear_count got %0d exp 5", count); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (evt_id !== 5'(ids[k]) || evt_ts !== t) begin
        errors++;
        $display("FAIL clear_head%0d got id=%0d ts=%0d exp id=%0d ts=%0d", k, evt_id, evt_ts, ids[k], t);
      end
      do_pop();
    end
  endtask

  task automatic test_reset_mid;
    alarm_in = 24'h00003F;
    tick(); tick();
    alarm_in = '0;
    tick(); tick(); tick();
    checks++;
    if (count !== 4'd4) begin errors++; $display("FAIL rmid_setup got %0d exp 4", count); end
    reset = 1'b1;
    alarm_in = 24'h000080;
    #1;
    checks++;
    if ({valid, evt_id, evt_ts, count, overflow, drop_count} !== '0) begin
      errors++;
      $display("FAIL rmid_async got v=%0b id=%0d ts=%0d cnt=%0d ovf=%0b drop=%0d exp all 0",
               valid, evt_id, evt_ts, count, overflow, drop_count);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rmid_latency valid got %0b exp 0", valid); end
    tick();
    checks++;
    if (valid !== 1'b1 || evt_id !== 5'd7 || evt_ts !== 16'd0 || count !== 4'd1) begin
      errors++;
      $display("FAIL rmid_event got v=%0b id=%0d ts=%0d cnt=%0d exp 1/7/0/1", valid, evt_id, evt_ts, count);
    end
    repeat (3) tick();
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL rmid_discard got %0d exp 1", count); end
    alarm_in = '0;
    do_pop();
    checks++;
    if (count !== 4'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_drained got cnt=%0d v=%0b exp 0/0", count, valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_full();
    test_drop();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/ats21_event_queue.md
# ats21_event_queue

Downstream consumer of the ATS21 alarm outputs. It converts the 24 per-alarm `finished` pulses on ATS21 `data[23:0]` into a timestamped, ordered event stream that a host drains one entry at a time. Each pulse is 2 cycles wide and several alarms can fire at once. The block turns each rising edge into exactly one event, queues events in a FIFO, and reports loss when the host falls behind.

## Interface
- `NUM_ALARMS`, default 24: number of alarm inputs, matches the ATS21 alarm count.
- `DEPTH`, default 8: FIFO entries, power of 2.
- `TS_WIDTH`, default 16: timestamp counter width, matches the ATS21 clock width.
- `clk`  in  1: clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `alarm_in`  in  NUM_ALARMS: ATS21 `data` bus, one bit per alarm.
- `pop`  in  1: host consumes the head entry this cycle.
- `clear_ovf`  in  1: clears `overflow` and `drop_count`.
- `valid`  out  1: FIFO non-empty; the head entry is presented.
- `evt_id`  out  5: alarm index of the head entry.
- `evt_ts`  out  TS_WIDTH: timestamp of the head entry.
- `count`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky; set when any event was dropped.
- `drop_count`  out  8: number of dropped events, saturates at 255.

## Operation
- `alarm_q` registers `alarm_in`.
- `rise = alarm_in & ~alarm_q`. A 2-cycle pulse yields exactly one rise.
- `ts_ctr` increments every cycle and wraps modulo 2^TS_WIDTH.
- Pending stage:
  - On `rise[i]` with `pending[i]`=0: set `pending[i]` and capture `pend_ts[i]` = `ts_ctr`.
  - On `rise[i]` with `pending[i]`=1: the new event is dropped. The original timestamp is kept, `overflow` is set, and `drop_count` is incremented (saturating).
  - Several simultaneous drops in one cycle each increment `drop_count`, clamped at 255.
- Grant stage:
  - Grant when `pending` is non-zero and space is available, i.e. `count < DEPTH` or `pop` is asserted this cycle.
  - Grant the lowest-index pending alarm. Push `{i, pend_ts[i]}` and clear `pending[i]`.
  - At most one push per cycle.
- Same-cycle grant and rise on the same alarm: the grant clears the old pending entry and the rise re-sets it with the new timestamp. This is not a drop.
- FIFO is first-word-fall-through. `evt_id`/`evt_ts` show the head whenever `valid`=1 and are 0 when empty.
- `pop` while empty is ignored. Push and pop in the same cycle leave `count` unchanged.
- `clear_ovf` in the same cycle as a drop: the drop wins, giving `overflow`=1 and `drop_count`=1.
- While the FIFO is full and `pop`=0, pending bits wait. The FIFO itself never overwrites entries.

## Timing
- Reset values: `alarm_q`, `pending`, `pend_ts`, `ts_ctr`, FIFO pointers and `count` = 0. Outputs: `valid`=0, `evt_id`=0, `evt_ts`=0, `overflow`=0, `drop_count`=0.
- `alarm_in` high at the first edge after reset counts as a rise.
- Latency, `alarm_in` rise to `valid`:
  - Edge N: rise sampled, `pending` set, `ts` captured as the `ts_ctr` value before increment.
  - Edge N+1: push.
  - `valid` is high after edge N+1.
- Simultaneous rises drain one per cycle in ascending index order.
- `count`, `overflow` and `drop_count` update on the same edge as the causing event.
- Reset mid-operation empties the FIFO and discards pending events immediately. No event is emitted for pulses in progress at reset release unless `alarm_in` is still high.

## Structure
- Package `ats21_pkg`:
  - Constants `NUM_ALARMS`=24, `ALARM_ID_W`=5, `TS_WIDTH`=16.
  - `typedef struct packed { logic [ALARM_ID_W-1:0] id; logic [TS_WIDTH-1:0] ts; } alarm_evt_t;`
  - ATS21 shares this package for its alarm count.
- Sub-module `ats21_evt_fifo`:
  - Synchronous FWFT FIFO of `alarm_evt_t` with push, pop, full, empty and count.
  - Extra MSB on the pointers for full/empty detection.
- Top level holds the edge detection, the pending/timestamp array, the priority grant and the drop accounting.

## Test plan
- Single alarm: 2-cycle pulse on `alarm_in[3]` at `ts_ctr`=10. Expect one entry with `evt_id`=3, `evt_ts`=10; `valid` rises 2 edges after the pulse starts; after `pop`, `count`=0.
- Simultaneous fire: `alarm_in` = 0x800101 (alarms 0, 8, 23) in one cycle. Expect pushes on 3 consecutive cycles, ids 0, 8, 23, all with the same `ts`.
- Full FIFO: fire 9 distinct alarms with no `pop`. Expect `count`=8 and alarm 8 held pending; after one `pop`, alarm 8 enters the next cycle; `overflow`=0.
- Drop: with the FIFO full and `pending[5]`=1, pulse alarm 5 again. Expect `overflow`=1, `drop_count`=1 and the original `ts` retained; 300 such drops give `drop_count`=255.
- Clear vs drop: `clear_ovf` alone → 0/0. `clear_ovf` in the same cycle as a drop → `overflow`=1, `drop_count`=1.
- Reset mid-stream: with 4 entries queued and 2 pending, assert `reset`. Expect all outputs 0 immediately (asynchronous); `alarm_in[7]` held high through release → event id 7, `ts`=0.
